// File: rtl/armleosoc_axi_pkg.sv
// Shared AXI definitions for the armleosoc interconnect: arbiter state encoding,
// AXI response codes and the packed-bus slice helper.
package armleosoc_axi_pkg;

  typedef enum logic [0:0] {
    STATE_IDLE   = 1'b0,
    STATE_ACTIVE = 1'b1
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // LSB of slice idx in a bus packing several width-bit fields back to back.
  function automatic int access_packed(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/armleosoc_arbiter_select.sv
// Combinational request selector: first requester at or after base_i, wrapping
// modulo N. With base_i tied to zero it degenerates to fixed lowest-index priority.
module armleosoc_arbiter_select #(
  parameter int N  = 2,
  parameter int HW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [HW-1:0] base_i,
  output logic [HW-1:0] idx_o,
  output logic          valid_o
);

  localparam logic [HW:0] NUM = (HW+1)'(N);

  // Scan candidates in priority order starting from the base pointer.
  always_comb begin
    logic [HW:0] cand;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, base_i} + (HW+1)'(i);
      cand = (cand >= NUM) ? (cand - NUM) : cand;
      if (!valid_o && req_i[cand[HW-1:0]]) begin
        idx_o   = cand[HW-1:0];
        valid_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/armleosoc_axi_read_arbiter.sv
// N-to-1 AXI4 AR/R arbiter, one transaction in flight, grant held until RLAST.
// Define ARMLEOSOC_AXI_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module armleosoc_axi_read_arbiter
  import armleosoc_axi_pkg::*;
#(
  parameter int OPT_NUMBER_OF_HOSTS = 2,
  parameter int ADDR_WIDTH          = 34,
  parameter int ID_WIDTH            = 4,
  parameter int DATA_WIDTH          = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,

  input  logic [OPT_NUMBER_OF_HOSTS-1:0]          upstream_axi_arvalid,
  output logic [OPT_NUMBER_OF_HOSTS-1:0]          upstream_axi_arready,
  input  logic [OPT_NUMBER_OF_HOSTS*ADDR_WIDTH-1:0] upstream_axi_araddr,
  input  logic [OPT_NUMBER_OF_HOSTS*8-1:0]        upstream_axi_arlen,
  input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]        upstream_axi_arsize,
  input  logic [OPT_NUMBER_OF_HOSTS*2-1:0]        upstream_axi_arburst,
  input  logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0] upstream_axi_arid,
  input  logic [OPT_NUMBER_OF_HOSTS-1:0]          upstream_axi_arlock,
  input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]        upstream_axi_arprot,

  output logic [OPT_NUMBER_OF_HOSTS-1:0]          upstream_axi_rvalid,
  input  logic [OPT_NUMBER_OF_HOSTS-1:0]          upstream_axi_rready,
  output logic [DATA_WIDTH-1:0]                   upstream_axi_rdata,
  output logic [1:0]                              upstream_axi_rresp,
  output logic                                    upstream_axi_rlast,
  output logic [ID_WIDTH-1:0]                     upstream_axi_rid,

  output logic                                    downstream_axi_arvalid,
  input  logic                                    downstream_axi_arready,
  output logic [ADDR_WIDTH-1:0]                   downstream_axi_araddr,
  output logic [7:0]                              downstream_axi_arlen,
  output logic [2:0]                              downstream_axi_arsize,
  output logic [1:0]                              downstream_axi_arburst,
  output logic [ID_WIDTH-1:0]                     downstream_axi_arid,
  output logic                                    downstream_axi_arlock,
  output logic [2:0]                              downstream_axi_arprot,

  input  logic                                    downstream_axi_rvalid,
  output logic                                    downstream_axi_rready,
  input  logic [1:0]                              downstream_axi_rresp,
  input  logic                                    downstream_axi_rlast,
  input  logic [DATA_WIDTH-1:0]                   downstream_axi_rdata,
  input  logic [ID_WIDTH-1:0]                     downstream_axi_rid
);

  localparam int N  = OPT_NUMBER_OF_HOSTS;
  localparam int HW = $clog2(N);

  arb_state_t      state_q;
  logic [HW-1:0]   grant_q;
  logic            ardone_q;
  logic            rdone_q;
  logic            ardone_d;
  logic            rdone_d;

  logic            active;
  logic            sel_arvalid;
  logic            sel_rready;
  logic [HW-1:0]   arb_base;
  logic [HW-1:0]   arb_idx;
  logic            arb_valid;

`ifdef ARMLEOSOC_AXI_ARB_ROUND_ROBIN_EN
  logic [HW-1:0]   rr_ptr_q;
  logic [HW-1:0]   rr_ptr_d;

  assign arb_base = rr_ptr_q;
  assign rr_ptr_d = (grant_q == HW'(N - 1)) ? '0 : (grant_q + HW'(1));
`else
  assign arb_base = '0;
`endif

  armleosoc_arbiter_select #(
    .N  (N),
    .HW (HW)
  ) u_select (
    .req_i   (upstream_axi_arvalid),
    .base_i  (arb_base),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Reset gates every handshake output immediately, not only after the clock edge.
  assign active      = rst_n && (state_q == STATE_ACTIVE);
  assign sel_arvalid = upstream_axi_arvalid[grant_q];
  assign sel_rready  = upstream_axi_rready[grant_q];

  assign downstream_axi_arvalid = active & sel_arvalid & ~ardone_q;
  assign downstream_axi_rready  = active & sel_rready & ~rdone_q;

  assign downstream_axi_araddr  = upstream_axi_araddr[access_packed(int'(grant_q), ADDR_WIDTH) +: ADDR_WIDTH];
  assign downstream_axi_arlen   = upstream_axi_arlen[access_packed(int'(grant_q), 8) +: 8];
  assign downstream_axi_arsize  = upstream_axi_arsize[access_packed(int'(grant_q), 3) +: 3];
  assign downstream_axi_arburst = upstream_axi_arburst[access_packed(int'(grant_q), 2) +: 2];
  assign downstream_axi_arid    = upstream_axi_arid[access_packed(int'(grant_q), ID_WIDTH) +: ID_WIDTH];
  assign downstream_axi_arlock  = upstream_axi_arlock[grant_q];
  assign downstream_axi_arprot  = upstream_axi_arprot[access_packed(int'(grant_q), 3) +: 3];

  assign upstream_axi_rdata = downstream_axi_rdata;
  assign upstream_axi_rresp = downstream_axi_rresp;
  assign upstream_axi_rlast = downstream_axi_rlast;
  assign upstream_axi_rid   = downstream_axi_rid;

  // Only the granted host ever sees arready/rvalid.
  always_comb begin
    upstream_axi_arready = '0;
    upstream_axi_rvalid  = '0;
    if (active) begin
      upstream_axi_arready[grant_q] = downstream_axi_arready & ~ardone_q;
      upstream_axi_rvalid[grant_q]  = downstream_axi_rvalid & ~rdone_q;
    end else begin
      upstream_axi_arready = '0;
      upstream_axi_rvalid  = '0;
    end
  end

  // Completion flags including this cycle's handshakes, so AR and RLAST may land together.
  assign ardone_d = ardone_q | (downstream_axi_arvalid & downstream_axi_arready);
  assign rdone_d  = rdone_q | (downstream_axi_rvalid & downstream_axi_rready & downstream_axi_rlast);

  // Transaction FSM: register a grant in IDLE, hold it until both AR and last R are done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= STATE_IDLE;
      grant_q  <= '0;
      ardone_q <= 1'b0;
      rdone_q  <= 1'b0;
`ifdef ARMLEOSOC_AXI_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      case (state_q)
        STATE_IDLE: begin
          ardone_q <= 1'b0;
          rdone_q  <= 1'b0;
          if (arb_valid) begin
            grant_q <= arb_idx;
            state_q <= STATE_ACTIVE;
          end else begin
            state_q <= STATE_IDLE;
          end
        end
        STATE_ACTIVE: begin
          if (ardone_d && rdone_d) begin
            state_q  <= STATE_IDLE;
            ardone_q <= 1'b0;
            rdone_q  <= 1'b0;
`ifdef ARMLEOSOC_AXI_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
          end else begin
            ardone_q <= ardone_d;
            rdone_q  <= rdone_d;
          end
        end
        default: begin
          state_q  <= STATE_IDLE;
          ardone_q <= 1'b0;
          rdone_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleosoc_axi_read_arbiter.sv
// Directed scoreboard bench for armleosoc_axi_read_arbiter (2 hosts); expectations
// follow ARMLEOSOC_AXI_ARB_ROUND_ROBIN_EN when it is defined.
module tb_armleosoc_axi_read_arbiter;
  import armleosoc_axi_pkg::*;

  localparam int N  = 2;
  localparam int AW = 34;
  localparam int IW = 4;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    logic [2:0]    prot;
  } ar_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]    up_arvalid, up_arready, up_rvalid, up_rready;
  logic [N*AW-1:0] up_araddr;
  logic [N*8-1:0]  up_arlen;
  logic [N*3-1:0]  up_arsize;
  logic [N*2-1:0]  up_arburst;
  logic [N*IW-1:0] up_arid;
  logic [N-1:0]    up_arlock;
  logic [N*3-1:0]  up_arprot;
  logic [DW-1:0]   up_rdata;
  logic [1:0]      up_rresp;
  logic            up_rlast;
  logic [IW-1:0]   up_rid;

  logic            ds_arvalid, ds_arready;
  logic [AW-1:0]   ds_araddr;
  logic [7:0]      ds_arlen;
  logic [2:0]      ds_arsize;
  logic [1:0]      ds_arburst;
  logic [IW-1:0]   ds_arid;
  logic            ds_arlock;
  logic [2:0]      ds_arprot;
  logic            ds_rvalid, ds_rready, ds_rlast;
  logic [1:0]      ds_rresp;
  logic [DW-1:0]   ds_rdata;
  logic [IW-1:0]   ds_rid;

  ar_exp_t arq0[$];
  ar_exp_t arq1[$];
  r_exp_t  rq[$];

  int vectors     = 0;
  int miscompares = 0;
  int rr_ptr_m    = 0;
  int txn         = 0;
  int w;
  logic [7:0]    len_m [N];
  logic [IW-1:0] id_m  [N];

  always #5 clk = ~clk;

  armleosoc_axi_read_arbiter #(
    .OPT_NUMBER_OF_HOSTS (N),
    .ADDR_WIDTH          (AW),
    .ID_WIDTH            (IW),
    .DATA_WIDTH          (DW)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .upstream_axi_arvalid   (up_arvalid),
    .upstream_axi_arready   (up_arready),
    .upstream_axi_araddr    (up_araddr),
    .upstream_axi_arlen     (up_arlen),
    .upstream_axi_arsize    (up_arsize),
    .upstream_axi_arburst   (up_arburst),
    .upstream_axi_arid      (up_arid),
    .upstream_axi_arlock    (up_arlock),
    .upstream_axi_arprot    (up_arprot),
    .upstream_axi_rvalid    (up_rvalid),
    .upstream_axi_rready    (up_rready),
    .upstream_axi_rdata     (up_rdata),
    .upstream_axi_rresp     (up_rresp),
    .upstream_axi_rlast     (up_rlast),
    .upstream_axi_rid       (up_rid),
    .downstream_axi_arvalid (ds_arvalid),
    .downstream_axi_arready (ds_arready),
    .downstream_axi_araddr  (ds_araddr),
    .downstream_axi_arlen   (ds_arlen),
    .downstream_axi_arsize  (ds_arsize),
    .downstream_axi_arburst (ds_arburst),
    .downstream_axi_arid    (ds_arid),
    .downstream_axi_arlock  (ds_arlock),
    .downstream_axi_arprot  (ds_arprot),
    .downstream_axi_rvalid  (ds_rvalid),
    .downstream_axi_rready  (ds_rready),
    .downstream_axi_rresp   (ds_rresp),
    .downstream_axi_rlast   (ds_rlast),
    .downstream_axi_rdata   (ds_rdata),
    .downstream_axi_rid     (ds_rid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] req);
    for (int i = 0; i < N; i++) begin
      int c = (rr_ptr_m + i) % N;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  task automatic done(input int h);
`ifdef ARMLEOSOC_AXI_ARB_ROUND_ROBIN_EN
    rr_ptr_m = (h + 1) % N;
`else
    rr_ptr_m = 0 * h;
`endif
    txn++;
  endtask

  task automatic request(input int h, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [IW-1:0] id);
    ar_exp_t a;
    a.addr = addr;
    a.len  = len;
    a.id   = id;
    a.prot = 3'(h + 1);
    up_araddr[h*AW +: AW]  = addr;
    up_arlen[h*8 +: 8]     = len;
    up_arsize[h*3 +: 3]    = 3'd2;
    up_arburst[h*2 +: 2]   = 2'b01;
    up_arid[h*IW +: IW]    = id;
    up_arlock[h]           = 1'b0;
    up_arprot[h*3 +: 3]    = a.prot;
    len_m[h] = len;
    id_m[h]  = id;
    if (h == 0) arq0.push_back(a);
    else        arq1.push_back(a);
    up_arvalid[h] = 1'b1;
  endtask

  task automatic check_ar(input int h);
    ar_exp_t a;
    if (h == 0 && arq0.size() != 0) a = arq0.pop_front();
    else if (h != 0 && arq1.size() != 0) a = arq1.pop_front();
    else a = '{default: '0};
    chk("ar_addr",  64'(ds_araddr),  64'(a.addr));
    chk("ar_len",   64'(ds_arlen),   64'(a.len));
    chk("ar_id",    64'(ds_arid),    64'(a.id));
    chk("ar_prot",  64'(ds_arprot),  64'(a.prot));
    chk("ar_size",  64'(ds_arsize),  64'd2);
    chk("ar_burst", 64'(ds_arburst), 64'd1);
  endtask

  task automatic drive_beat(input int h, input int b, input int nbeats);
    r_exp_t r;
    r.data = DW'(32'hD000_0000 + (h << 16) + (txn << 8) + b);
    r.resp = (b == 1) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    r.last = (b == nbeats - 1);
    r.id   = id_m[h];
    rq.push_back(r);
    ds_rvalid = 1'b1;
    ds_rdata  = r.data;
    ds_rresp  = r.resp;
    ds_rlast  = r.last;
    ds_rid    = r.id;
  endtask

  task automatic check_r();
    r_exp_t r;
    if (rq.size() != 0) begin
      r = rq.pop_front();
      chk("r_data", 64'(up_rdata), 64'(r.data));
      chk("r_resp", 64'(up_rresp), 64'(r.resp));
      chk("r_last", 64'(up_rlast), 64'(r.last));
      chk("r_id",   64'(up_rid),   64'(r.id));
    end
  endtask

  // Starts in the IDLE cycle where host h's request is visible; ends in the following IDLE cycle.
  task automatic serve(input int h, input int ar_delay, input int bp_beat, input int bp_len);
    logic [N-1:0] me;
    int nbeats;
    me = 2'b01 << h;
    nbeats = int'(len_m[h]) + 1;
    #1;
    chk("grant_cycle_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("grant_cycle_up_arready", 64'(up_arready), 64'd0);
    tick();
    for (int c = 0; c < ar_delay; c++) begin
      ds_arready = 1'b0;
      #1;
      chk("ar_stall_ds_arvalid", 64'(ds_arvalid), 64'd1);
      chk("ar_stall_up_arready", 64'(up_arready), 64'd0);
      tick();
    end
    ds_arready = 1'b1;
    #1;
    chk("ar_ds_arvalid", 64'(ds_arvalid), 64'd1);
    chk("ar_up_arready", 64'(up_arready), 64'(me));
    check_ar(h);
    tick();
    #1;
    chk("ardone_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("ardone_up_arready", 64'(up_arready), 64'd0);
    tick();
    up_arvalid[h] = 1'b0;
    ds_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(h, b, nbeats);
      if (b == bp_beat) begin
        for (int k = 0; k < bp_len; k++) begin
          up_rready[h] = 1'b0;
          #1;
          chk("bp_ds_rready", 64'(ds_rready), 64'd0);
          chk("bp_up_rvalid", 64'(up_rvalid), 64'(me));
          chk("bp_rdata_held", 64'(up_rdata), 64'(rq[rq.size()-1].data));
          tick();
        end
      end
      up_rready[h] = 1'b1;
      #1;
      chk("beat_up_rvalid", 64'(up_rvalid), 64'(me));
      chk("beat_ds_rready", 64'(ds_rready), 64'd1);
      chk("beat_up_arready", 64'(up_arready), 64'd0);
      if (up_rvalid[h] && up_rready[h]) check_r();
      tick();
    end
    ds_rvalid = 1'b0;
    ds_rlast  = 1'b0;
    #1;
    chk("post_up_rvalid", 64'(up_rvalid), 64'd0);
    chk("post_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("post_ds_rready", 64'(ds_rready), 64'd0);
    chk("post_beats_outstanding", 64'(rq.size()), 64'd0);
    done(h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    up_arvalid = '0; up_rready = 2'b11;
    up_araddr = '0; up_arlen = '0; up_arsize = '0; up_arburst = '0;
    up_arid = '0; up_arlock = '0; up_arprot = '0;
    ds_arready = 1'b1; ds_rvalid = 1'b1; ds_rlast = 1'b1;
    ds_rresp = AXI_RESP_OKAY; ds_rdata = '0; ds_rid = '0;
    up_arvalid = 2'b11;
    repeat (2) tick();
    chk("reset_up_arready", 64'(up_arready), 64'd0);
    chk("reset_up_rvalid", 64'(up_rvalid), 64'd0);
    chk("reset_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("reset_ds_rready", 64'(ds_rready), 64'd0);
    up_arvalid = '0; ds_arready = 1'b0; ds_rvalid = 1'b0; ds_rlast = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single host, 4-beat burst, router accepts AR one cycle late.
    request(0, 34'h100, 8'd3, 4'h3);
    serve(0, 1, -1, 0);

    // Contention round A.
    request(0, 34'h2000, 8'd3, 4'h5);
    request(1, 34'h2_0000_3000, 8'd1, 4'h9);
    w = pick(2'b11);
    serve(w, 0, -1, 0);
    serve(1 - w, 2, -1, 0);

    // Contention round B with host backpressure mid-burst.
    request(0, 34'h4000, 8'd3, 4'h1);
    request(1, 34'h1_0000_5000, 8'd3, 4'h2);
    w = pick(2'b11);
    serve(w, 0, 1, 5);
    serve(1 - w, 0, -1, 0);

    // AR and the only (last) R beat in the same cycle.
    request(0, 34'h3_0000_0040, 8'd0, 4'hA);
    #1;
    chk("same_grant_ds_arvalid", 64'(ds_arvalid), 64'd0);
    tick();
    ds_arready = 1'b1;
    drive_beat(0, 0, 1);
    #1;
    chk("same_ds_arvalid", 64'(ds_arvalid), 64'd1);
    chk("same_up_arready", 64'(up_arready), 64'd1);
    chk("same_up_rvalid", 64'(up_rvalid), 64'd1);
    chk("same_ds_rready", 64'(ds_rready), 64'd1);
    check_ar(0);
    if (up_rvalid[0]) check_r();
    tick();
    up_arvalid[0] = 1'b0;
    ds_rdata = 32'hBAD0_BAD0;
    #1;
    chk("same_extra_up_rvalid", 64'(up_rvalid), 64'd0);
    chk("same_extra_ds_rready", 64'(ds_rready), 64'd0);
    chk("same_extra_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("same_beats_outstanding", 64'(rq.size()), 64'd0);
    ds_rvalid = 1'b0; ds_rlast = 1'b0; ds_arready = 1'b0;
    done(0);
    tick();

    // Reset after beat 2 of 4 while host1 holds the grant.
    request(1, 34'h8000, 8'd3, 4'hC);
    #1;
    chk("rst_grant_ds_arvalid", 64'(ds_arvalid), 64'd0);
    tick();
    ds_arready = 1'b1;
    #1;
    chk("rst_up_arready", 64'(up_arready), 64'd2);
    check_ar(1);
    tick();
    up_arvalid[1] = 1'b0;
    ds_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(1, b, 4);
      #1;
      chk("rst_beat_up_rvalid", 64'(up_rvalid), 64'd2);
      if (up_rvalid[1]) check_r();
      tick();
    end
    drive_beat(1, 2, 4);
    up_arvalid = 2'b11;
    ds_arready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_low_up_rvalid", 64'(up_rvalid), 64'd0);
    chk("rst_low_up_arready", 64'(up_arready), 64'd0);
    chk("rst_low_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("rst_low_ds_rready", 64'(ds_rready), 64'd0);
    tick();
    chk("rst_edge_up_rvalid", 64'(up_rvalid), 64'd0);
    chk("rst_edge_ds_rready", 64'(ds_rready), 64'd0);
    rst_n = 1'b1;
    up_arvalid = '0;
    ds_rvalid = 1'b0; ds_rlast = 1'b0; ds_arready = 1'b0;
    rq.delete();
    rr_ptr_m = 0;
    txn++;
    #1;
    chk("rst_idle_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("rst_idle_ds_rready", 64'(ds_rready), 64'd0);
    chk("rst_idle_up_rvalid", 64'(up_rvalid), 64'd0);
    tick();

    // After reset the pointer restarts at host0.
    request(0, 34'h6000, 8'd1, 4'h4);
    request(1, 34'h7000, 8'd2, 4'h6);
    w = pick(2'b11);
    serve(w, 0, -1, 0);
    serve(1 - w, 1, -1, 0);

    chk("final_ar_outstanding", 64'(arq0.size() + arq1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
